// File: rtl/aes_byte_stream_if.sv
// Byte-stream wrapper around a combinational AES-128 core.
// Key and plaintext bytes are collected MSB-first into 128-bit registers.
// The core is then given CORE_WAIT cycles to settle, and the ciphertext is
// streamed back out one byte at a time.
module aes_byte_stream_if #(
  parameter int unsigned CORE_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_key_sel,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         key_loaded,
  output logic         busy
);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SEND} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(CORE_WAIT - 1);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;
  logic [4:0]   key_cnt_q, key_cnt_d;
  logic [4:0]   pt_cnt_q, pt_cnt_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic         key_loaded_q, key_loaded_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic [7:0]   out_data_q, out_data_d;
  logic         key_acc, pt_acc;

  // Key bytes are always welcome in LOAD; plaintext stalls once 16 are held.
  assign in_ready = (state_q == ST_LOAD) && (in_key_sel || !pt_cnt_q[4]);
  assign key_acc  = in_valid && in_ready && in_key_sel;
  assign pt_acc   = in_valid && in_ready && !in_key_sel;

  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_data       = out_data_q;
  assign busy           = busy_q;
  assign key_loaded     = key_loaded_q;

  // Next-state logic for the LOAD/WAIT/SEND sequencer and its datapath.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    key_cnt_d    = key_cnt_q;
    pt_cnt_d     = pt_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    idx_d        = idx_q;
    key_loaded_d = key_loaded_q;
    out_data_d   = '0;

    case (state_q)
      ST_LOAD: begin
        if (key_acc) begin
          for (int i = 0; i < 16; i++) begin
            if (key_cnt_q[3:0] == 4'(i)) key_d[127-8*i -: 8] = in_data;
          end
          // Starting a new key invalidates the old one until it is complete.
          if (key_cnt_q == 5'd0) key_loaded_d = 1'b0;
          if (key_cnt_q == 5'd15) begin
            key_loaded_d = 1'b1;
            key_cnt_d    = 5'd0;
          end else begin
            key_cnt_d = key_cnt_q + 5'd1;
          end
        end
        if (pt_acc) begin
          for (int i = 0; i < 16; i++) begin
            if (pt_cnt_q[3:0] == 4'(i)) pt_d[127-8*i -: 8] = in_data;
          end
          pt_cnt_d = pt_cnt_q + 5'd1;
        end
        if ((pt_cnt_d == 5'd16) && key_loaded_d) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          ct_d    = core_ciphertext;
          idx_d   = '0;
          state_d = ST_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == 4'd15) begin
            state_d  = ST_LOAD;
            pt_cnt_d = '0;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Outputs are registered from the next-state values so they line up with the state.
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_LOAD);
    out_last_d  = (state_d == ST_SEND) && (idx_d == 4'd15);
    if (state_d == ST_SEND) begin
      for (int i = 0; i < 16; i++) begin
        if (idx_d == 4'(i)) out_data_d = ct_d[127-8*i -: 8];
      end
    end
  end

  // State and datapath registers; reset aborts any block in flight and drops the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      key_cnt_q    <= '0;
      pt_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      idx_q        <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      key_cnt_q    <= key_cnt_d;
      pt_cnt_q     <= pt_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      idx_q        <= idx_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule
